// File: rtl/dsi_lanes_sequencer.sv
// dsi_lanes_sequencer
// Sequences one DSI clock lane and up to LANES data lanes for each high-speed
// burst. It starts the clock lane ahead of the data lanes, moves one byte per
// lane per transfer with all lanes in lockstep, and then closes the burst with
// the data-lane, clock-post and clock-lane shutdown ordering.
//
// Optional feature macro: DSI_CLK_CONTINUOUS_EN. When it is defined, the clock
// lane is started once on enable and keeps running between bursts.
//
// Ports:
//   clk_sys, rst          single clock, asynchronous active-high reset
//   enable                link enable from configuration
//   pkt_data/valid/last   packet stream in; pkt_ready is the consume strobe
//   lines_enable          lane controller enable (0 only in DISABLED)
//   clk_start_rqst        registered one-cycle pulse to the clock lane
//   clk_fin_rqst          registered level, clock lane finish
//   clk_active            clock lane status
//   data_start_rqst       registered one-cycle pulse to the data lanes
//   data_fin_rqst         registered level, data lanes finish
//   data_active/data_rqst per-lane status and byte request
//   lane_data             byte i to data lane i (zero-latency from data_rqst)
//   busy                  burst in progress (not DISABLED/IDLE)
//   err_underflow         sticky, cleared when clk_start_rqst is issued
//   dbg_state             current FSM state, for observation only
//
// Handshake: a word moves on the pkt stream in every cycle where
// pkt_valid && pkt_ready; pkt_ready is high only in DATA_ACTIVE while every
// active lane requests a byte, and pkt_ready never depends on it being taken.
module dsi_lanes_sequencer #(
  parameter int LANES      = 4,
  parameter int T_CLK_PRE  = 4,
  parameter int T_CLK_POST = 4
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] pkt_data,
  input  logic        pkt_valid,
  input  logic        pkt_last,
  output logic        pkt_ready,
  output logic        lines_enable,
  output logic        clk_start_rqst,
  output logic        clk_fin_rqst,
  input  logic        clk_active,
  output logic        data_start_rqst,
  output logic        data_fin_rqst,
  input  logic [3:0]  data_active,
  input  logic [3:0]  data_rqst,
  output logic [31:0] lane_data,
  output logic        busy,
  output logic        err_underflow,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_DISABLED, S_IDLE, S_CLK_START, S_CLK_PRE, S_DATA_START,
    S_DATA_ACTIVE, S_DATA_FIN, S_CLK_POST, S_CLK_FIN
  } state_t;

  // Lanes at index >= LANES are masked out of every reduction and output.
  localparam logic [3:0]  ACT_MASK  = 4'((5'd1 << LANES) - 5'd1);
  localparam logic [31:0] BYTE_MASK = 32'((33'd1 << (8 * LANES)) - 33'd1);
  localparam logic [7:0]  PRE_LOAD  = 8'(T_CLK_PRE - 1);
  localparam logic [7:0]  POST_LOAD = 8'(T_CLK_POST - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       start_clk, start_data;
  logic       all_act, any_act, all_rqst, in_data, underflow_now;

  assign all_act  = ((data_active & ACT_MASK) == ACT_MASK);
  assign any_act  = |(data_active & ACT_MASK);
  assign all_rqst = ((data_rqst & ACT_MASK) == ACT_MASK);
  assign in_data  = (state == S_DATA_ACTIVE);

  assign pkt_ready     = in_data && all_rqst && pkt_valid;
  assign lane_data     = (in_data && pkt_valid) ? (pkt_data & BYTE_MASK) : 32'h0;
  assign underflow_now = in_data && all_rqst && !pkt_valid;
  assign lines_enable  = (state != S_DISABLED);
  assign busy          = (state != S_DISABLED) && (state != S_IDLE);
  assign dbg_state     = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    start_clk  = 1'b0;
    start_data = 1'b0;
    case (state)
      S_DISABLED: begin
        if (enable) begin
          state_next = S_IDLE;
`ifdef DSI_CLK_CONTINUOUS_EN
          start_clk  = 1'b1;
`endif
        end
      end
      S_IDLE: begin
        // A disabled link never starts a burst, even with a word waiting.
        if (!enable) begin
          state_next = S_DISABLED;
        end else if (pkt_valid) begin
`ifdef DSI_CLK_CONTINUOUS_EN
          if (clk_active) begin
            state_next = S_CLK_PRE;
            cnt_next   = PRE_LOAD;
          end
`else
          state_next = S_CLK_START;
          start_clk  = 1'b1;
`endif
        end
      end
      S_CLK_START: begin
        if (clk_active) begin
          state_next = S_CLK_PRE;
          cnt_next   = PRE_LOAD;
        end
      end
      S_CLK_PRE: begin
        if (cnt == 8'd0) begin
          state_next = S_DATA_START;
          start_data = 1'b1;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      S_DATA_START: begin
        if (all_act) state_next = S_DATA_ACTIVE;
      end
      S_DATA_ACTIVE: begin
        if (pkt_ready && pkt_last) state_next = S_DATA_FIN;
      end
      S_DATA_FIN: begin
        if (!any_act) begin
          state_next = S_CLK_POST;
          cnt_next   = POST_LOAD;
        end
      end
      S_CLK_POST: begin
        if (cnt == 8'd0) begin
`ifdef DSI_CLK_CONTINUOUS_EN
          state_next = S_IDLE;
`else
          state_next = S_CLK_FIN;
`endif
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      S_CLK_FIN: begin
        if (!clk_active) state_next = S_IDLE;
      end
      default: state_next = S_DISABLED;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state           <= S_DISABLED;
      cnt             <= 8'd0;
      clk_start_rqst  <= 1'b0;
      data_start_rqst <= 1'b0;
      data_fin_rqst   <= 1'b0;
      clk_fin_rqst    <= 1'b0;
      err_underflow   <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      clk_start_rqst  <= start_clk;
      data_start_rqst <= start_data;
      // Finish levels follow "in the state and staying there", so they rise
      // one cycle after entry and drop one cycle after the exit condition.
      data_fin_rqst   <= (state == S_DATA_FIN) && (state_next == S_DATA_FIN);
`ifdef DSI_CLK_CONTINUOUS_EN
      if ((state == S_IDLE) && (state_next == S_DISABLED))
        clk_fin_rqst <= 1'b1;
      else if (!clk_active || start_clk)
        clk_fin_rqst <= 1'b0;
`else
      clk_fin_rqst    <= (state == S_CLK_FIN) && (state_next == S_CLK_FIN);
`endif
      if (start_clk)
        err_underflow <= 1'b0;
      else if (underflow_now)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dsi_lanes_sequencer.sv
// Self-checking bench for dsi_lanes_sequencer. Two instances share stimulus:
// u_dut4 (LANES=4) and u_dut2 (LANES=2, its upper request bits randomised).
// Lane controllers are played by the main sequence with bounded waits.
module tb_dsi_lanes_sequencer;

  localparam int T_PRE  = 4;
  localparam int T_POST = 4;

  localparam logic [3:0] ST_DISABLED    = 4'd0;
  localparam logic [3:0] ST_IDLE        = 4'd1;
  localparam logic [3:0] ST_DATA_ACTIVE = 4'd5;
  localparam logic [3:0] ST_DATA_FIN    = 4'd6;
  localparam logic [3:0] ST_CLK_POST    = 4'd7;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst, enable, pkt_valid, pkt_last, clk_active;
  logic [31:0] pkt_data;
  logic [3:0]  data_active, data_rqst;
  logic [1:0]  hi2;
  logic [3:0]  data_rqst2;
  assign data_rqst2 = {hi2, data_rqst[1:0]};

  logic        pkt_ready, lines_enable, clk_start_rqst, clk_fin_rqst;
  logic        data_start_rqst, data_fin_rqst, busy, err_underflow;
  logic [31:0] lane_data;
  logic [3:0]  dbg_state;

  logic        pkt_ready_2, lines_enable_2, clk_start_rqst_2, clk_fin_rqst_2;
  logic        data_start_rqst_2, data_fin_rqst_2, busy_2, err_underflow_2;
  logic [31:0] lane_data_2;
  logic [3:0]  dbg_state_2;

  dsi_lanes_sequencer #(.LANES(4), .T_CLK_PRE(T_PRE), .T_CLK_POST(T_POST)) u_dut4 (
    .clk_sys(clk_sys), .rst(rst), .enable(enable),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
    .pkt_ready(pkt_ready), .lines_enable(lines_enable),
    .clk_start_rqst(clk_start_rqst), .clk_fin_rqst(clk_fin_rqst),
    .clk_active(clk_active), .data_start_rqst(data_start_rqst),
    .data_fin_rqst(data_fin_rqst), .data_active(data_active),
    .data_rqst(data_rqst), .lane_data(lane_data), .busy(busy),
    .err_underflow(err_underflow), .dbg_state(dbg_state)
  );

  dsi_lanes_sequencer #(.LANES(2), .T_CLK_PRE(T_PRE), .T_CLK_POST(T_POST)) u_dut2 (
    .clk_sys(clk_sys), .rst(rst), .enable(enable),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
    .pkt_ready(pkt_ready_2), .lines_enable(lines_enable_2),
    .clk_start_rqst(clk_start_rqst_2), .clk_fin_rqst(clk_fin_rqst_2),
    .clk_active(clk_active), .data_start_rqst(data_start_rqst_2),
    .data_fin_rqst(data_fin_rqst_2), .data_active(data_active),
    .data_rqst(data_rqst2), .lane_data(lane_data_2), .busy(busy_2),
    .err_underflow(err_underflow_2), .dbg_state(dbg_state_2)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_clk_start = 0;
  int n_clk_fin_cyc = 0;
  int n_ready = 0;
  bit in_burst = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] exp2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {pkt_ready, lane_data} are pushed by the driver and popped here,
  // in the same cycle, away from the active edge.
  always @(negedge clk_sys) begin
    logic [32:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_lane4", {31'h0, pkt_ready, lane_data}, {31'h0, e});
    end
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      check("sb_lane2", {31'h0, pkt_ready_2, lane_data_2}, {31'h0, e});
    end
    if (clk_start_rqst) n_clk_start++;
    if (clk_fin_rqst)   n_clk_fin_cyc++;
    if (pkt_ready)      n_ready++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: sig = clk_start_rqst;
      1: sig = data_start_rqst;
      2: sig = data_fin_rqst;
      default: sig = clk_fin_rqst;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input int limit, output int n);
    n = 0;
    while (!sig(which) && n < limit) begin
      tick();
      n++;
    end
    check({name, "_seen"}, {63'h0, sig(which)}, 64'h1);
  endtask

  task automatic drive_cycle(input logic [31:0] d, input logic v, input logic l, input logic [3:0] r);
    logic all_r;
    logic [32:0] e4, e2;
    pkt_data  = d;
    pkt_valid = v;
    pkt_last  = l;
    data_rqst = r;
    hi2       = 2'($urandom_range(0, 3));
    all_r     = (r == 4'hF);
    e4 = '0;
    e2 = '0;
    if (in_burst) begin
      e4 = {all_r && v, v ? d : 32'h0};
      e2 = {all_r && v, v ? {16'h0, d[15:0]} : 32'h0};
    end
    exp_q.push_back(e4);
    exp2_q.push_back(e2);
    if (in_burst && all_r && v && l) in_burst = 1'b0;
    tick();
  endtask

  // From IDLE with a word waiting, up to the first cycle of DATA_ACTIVE.
  task automatic start_burst(input logic [31:0] d);
    int n;
    int cs0;
    cs0 = n_clk_start;
    pkt_data  = d;
    pkt_valid = 1'b1;
    pkt_last  = 1'b0;
    data_rqst = 4'h0;
    wait_sig("clk_start", 0, 20, n);
    check("err_cleared_on_start", {63'h0, err_underflow}, 64'h0);
    clk_active = 1'b1;
    wait_sig("data_start", 1, 30, n);
    check("clk_pre_latency", 64'(n), 64'(T_PRE + 1));
    check("one_clk_start_pulse", 64'(n_clk_start - cs0), 64'd1);
    data_active = 4'hF;
    tick();
    check("data_start_pulse_width", {63'h0, data_start_rqst}, 64'h0);
    check("state_data_active", {60'h0, dbg_state}, {60'h0, ST_DATA_ACTIVE});
    in_burst = 1'b1;
  endtask

  // From the first cycle of DATA_FIN back to IDLE.
  task automatic finish_burst(input logic v_after);
    int n;
    pkt_valid = v_after;
    data_rqst = 4'h0;
    check("state_data_fin", {60'h0, dbg_state}, {60'h0, ST_DATA_FIN});
    check("data_fin_rise_delay", {63'h0, data_fin_rqst}, 64'h0);
    tick();
    check("data_fin_rqst_high", {63'h0, data_fin_rqst}, 64'h1);
    data_active = 4'h0;
    tick();
    check("data_fin_rqst_fall", {63'h0, data_fin_rqst}, 64'h0);
    check("state_clk_post", {60'h0, dbg_state}, {60'h0, ST_CLK_POST});
    wait_sig("clk_fin", 3, 30, n);
    // Lanes idle -> CLK_POST entry, T_POST cycles there, CLK_FIN entry, then
    // the registered level rises.
    check("clk_post_latency", 64'(n + 1), 64'(T_POST + 2));
    clk_active = 1'b0;
    tick();
    check("clk_fin_rqst_fall", {63'h0, clk_fin_rqst}, 64'h0);
    check("state_idle_after_burst", {60'h0, dbg_state}, {60'h0, ST_IDLE});
    check("dut2_state_idle", {60'h0, dbg_state_2}, {60'h0, ST_IDLE});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic [3:0]  rqst;
    logic [1:0]  hi;
    logic [31:0] exp_lane4;
    logic [31:0] exp_lane2;
    logic        exp_ready;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int r0;
    int cs0;
    logic [31:0] words [3];
    words[0] = 32'h03020100;
    words[1] = 32'h07060504;
    words[2] = 32'h0B0A0908;

    vecs[0] = '{32'hAABBCCDD, 1'b1, 1'b0, 4'h0, 2'b11, 32'hAABBCCDD, 32'h0000CCDD, 1'b0, 1'b0};
    vecs[1] = '{32'hAABBCCDD, 1'b1, 1'b0, 4'hF, 2'b00, 32'hAABBCCDD, 32'h0000CCDD, 1'b1, 1'b0};
    vecs[2] = '{32'h11223344, 1'b0, 1'b0, 4'hF, 2'b10, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[3] = '{32'h11223344, 1'b0, 1'b0, 4'hF, 2'b01, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{32'h55667788, 1'b1, 1'b0, 4'h0, 2'b11, 32'h55667788, 32'h00007788, 1'b0, 1'b1};
    vecs[5] = '{32'h99AABBCC, 1'b1, 1'b1, 4'hF, 2'b10, 32'h99AABBCC, 32'h0000BBCC, 1'b1, 1'b1};

    rst = 1'b1; enable = 1'b1; pkt_valid = 1'b0; pkt_last = 1'b0;
    clk_active = 1'b0; pkt_data = 32'h0; data_active = 4'h0;
    data_rqst = 4'h0; hi2 = 2'b00;
    #22;
    check("reset_outputs", {31'h0, pkt_ready, lines_enable, clk_start_rqst, clk_fin_rqst,
          data_start_rqst, data_fin_rqst, busy, err_underflow, lane_data}, 64'h0);
    check("reset_state", {60'h0, dbg_state}, {60'h0, ST_DISABLED});
    @(posedge clk_sys); #1;
    rst = 1'b0;
    enable = 1'b0;
    tick();
    check("disabled_holds", {62'h0, lines_enable, busy}, 64'h0);
    enable = 1'b1;
    tick();
    check("idle_lines_enable", {62'h0, lines_enable, busy}, 64'h2);

`ifdef DSI_CLK_CONTINUOUS_EN
    // The enable edge starts the clock lane; it then runs across bursts.
    check("cont_start_on_enable", 64'(n_clk_start), 64'd1);
    clk_active = 1'b1;
    for (int b = 0; b < 2; b++) begin
      pkt_data  = 32'h10203040 + 32'(b);
      pkt_valid = 1'b1;
      wait_sig("cont_data_start", 1, 30, n);
      data_active = 4'hF;
      tick();
      in_burst = 1'b1;
      drive_cycle(32'h10203040 + 32'(b), 1'b1, 1'b1, 4'hF);
      pkt_valid = 1'b0;
      data_rqst = 4'h0;
      tick();
      data_active = 4'h0;
      n = 0;
      while (busy && n < 30) begin
        tick();
        n++;
      end
      check("cont_back_to_idle", {60'h0, dbg_state}, {60'h0, ST_IDLE});
    end
    check("cont_single_clk_start", 64'(n_clk_start), 64'd1);
    check("cont_no_clk_fin", 64'(n_clk_fin_cyc), 64'd0);
    enable = 1'b0;
    wait_sig("cont_clk_fin", 3, 10, n);
    check("cont_disabled", {60'h0, dbg_state}, {60'h0, ST_DISABLED});
    tick();
    tick();
    check("cont_clk_fin_held", {63'h0, clk_fin_rqst}, 64'h1);
    clk_active = 1'b0;
    tick();
    check("cont_clk_fin_fall", {63'h0, clk_fin_rqst}, 64'h0);
`else
    // Basic burst: three words, each lane answering on the third cycle.
    r0 = n_ready;
    start_burst(words[0]);
    for (int w = 0; w < 3; w++) begin
      drive_cycle(words[w], 1'b1, 1'b0, 4'h0);
      drive_cycle(words[w], 1'b1, 1'b0, 4'h0);
      drive_cycle(words[w], 1'b1, (w == 2), 4'hF);
    end
    finish_burst(1'b0);
    check("three_pkt_ready", 64'(n_ready - r0), 64'd3);
    check("no_underflow_yet", {62'h0, err_underflow, err_underflow_2}, 64'h0);

    // Table-driven burst: LANES=2 masking, upper request bits, underflow.
    start_burst(32'hAABBCCDD);
    for (int i = 0; i < 6; i++) begin
      pkt_data  = vecs[i].data;
      pkt_valid = vecs[i].valid;
      pkt_last  = vecs[i].last;
      data_rqst = vecs[i].rqst;
      hi2       = vecs[i].hi;
      #2;
      check($sformatf("vec%0d_lane4", i), {32'h0, lane_data}, {32'h0, vecs[i].exp_lane4});
      check($sformatf("vec%0d_lane2", i), {32'h0, lane_data_2}, {32'h0, vecs[i].exp_lane2});
      check($sformatf("vec%0d_ready", i), {62'h0, pkt_ready, pkt_ready_2},
            {62'h0, vecs[i].exp_ready, vecs[i].exp_ready});
      check($sformatf("vec%0d_err", i), {62'h0, err_underflow, err_underflow_2},
            {62'h0, vecs[i].exp_err, vecs[i].exp_err});
      tick();
    end
    in_burst = 1'b0;
    finish_burst(1'b0);
    check("underflow_sticky", {62'h0, err_underflow, err_underflow_2}, 64'h3);

    // enable drops mid-burst: burst completes, then DISABLED with no restart.
    start_burst(32'h01010101);
    drive_cycle(32'h01010101, 1'b1, 1'b0, 4'h0);
    enable = 1'b0;
    drive_cycle(32'h01010101, 1'b1, 1'b0, 4'h0);
    drive_cycle(32'h01010101, 1'b1, 1'b1, 4'hF);
    finish_burst(1'b1);
    tick();
    check("disabled_after_burst", {60'h0, dbg_state}, {60'h0, ST_DISABLED});
    cs0 = n_clk_start;
    repeat (10) tick();
    check("no_restart_disabled", 64'(n_clk_start - cs0), 64'd0);
    check("disabled_lines_off", {62'h0, lines_enable, busy}, 64'h0);

    // Reset asserted in CLK_POST.
    enable = 1'b1;
    start_burst(32'h5A5A5A5A);
    drive_cycle(32'h5A5A5A5A, 1'b1, 1'b1, 4'hF);
    pkt_valid = 1'b0;
    data_rqst = 4'h0;
    tick();
    data_active = 4'h0;
    tick();
    check("state_clk_post_pre_rst", {60'h0, dbg_state}, {60'h0, ST_CLK_POST});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {31'h0, pkt_ready, lines_enable, clk_start_rqst, clk_fin_rqst,
          data_start_rqst, data_fin_rqst, busy, err_underflow, lane_data}, 64'h0);
    check("async_reset_state", {60'h0, dbg_state}, {60'h0, ST_DISABLED});
    clk_active = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("idle_after_reset", {60'h0, dbg_state}, {60'h0, ST_IDLE});
    check("lines_after_reset", {63'h0, lines_enable}, 64'h1);
`endif

    tick();
    check("sb_queue_drained", 64'(exp_q.size() + exp2_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
